// File: rtl/tinv_bus_rx_arb.sv
// Receive controller for a shared inverting-tristate bus: round-robin grants with
// complementary enables, turnaround gaps, and a registered valid/ready output word.
module tinv_bus_rx_arb #(
  parameter  int NSRC = 4,
  parameter  int W    = 8,
  parameter  int TURN = 1,
  localparam int IW   = $clog2(NSRC)
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [NSRC-1:0] REQ,
  output logic [NSRC-1:0] EN,
  output logic [NSRC-1:0] EN_BAR,
  input  logic [W-1:0]    BUS,
  output logic [W-1:0]    DOUT,
  output logic            DVALID,
  input  logic            DREADY,
  output logic [IW-1:0]   SRC_ID,
  output logic            BUSY
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_TURN
  } state_t;

  state_t          state_q, state_d;
  logic [NSRC-1:0] en_q, en_d;
  logic [NSRC-1:0] en_bar_q, en_bar_d;
  logic [W-1:0]    dout_q, dout_d;
  logic            dvalid_q, dvalid_d;
  logic [IW-1:0]   src_id_q, src_id_d;
  logic            busy_q, busy_d;
  logic [IW-1:0]   last_q, last_d;
  logic [2:0]      cnt_q, cnt_d;

  logic            found;
  logic [IW-1:0]   sel;
  logic [IW-1:0]   idx;
  logic            slot_free;

  // Scan LAST+1 .. LAST+NSRC with an explicit wrap so non-power-of-2 NSRC stays in range.
  always_comb begin
    found = 1'b0;
    sel   = last_q;
    idx   = last_q;
    for (int unsigned k = 0; k < NSRC; k++) begin
      idx = (idx == IW'(NSRC - 1)) ? '0 : idx + 1'b1;
      if (!found && REQ[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    en_d      = '0;
    last_d    = last_q;
    cnt_d     = cnt_q;
    dout_d    = dout_q;
    src_id_d  = src_id_q;
    dvalid_d  = dvalid_q && !DREADY;
    slot_free = !dvalid_q || DREADY;

    case (state_q)
      S_IDLE: begin
        if (found && slot_free) begin
          state_d     = S_GRANT;
          en_d[sel]   = 1'b1;
          last_d      = sel;
        end
      end
      S_GRANT: begin
        dout_d   = ~BUS;
        src_id_d = last_q;
        dvalid_d = 1'b1;
        state_d  = S_TURN;
        cnt_d    = 3'(TURN - 1);
      end
      S_TURN: begin
        if (cnt_q == '0) state_d = S_IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    en_bar_d = ~en_d;
    busy_d   = (state_d != S_IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= S_IDLE;
      en_q     <= '0;
      en_bar_q <= '1;
      dout_q   <= '0;
      dvalid_q <= 1'b0;
      src_id_q <= '0;
      busy_q   <= 1'b0;
      last_q   <= IW'(NSRC - 1);
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      en_q     <= en_d;
      en_bar_q <= en_bar_d;
      dout_q   <= dout_d;
      dvalid_q <= dvalid_d;
      src_id_q <= src_id_d;
      busy_q   <= busy_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
    end
  end

  assign EN     = en_q;
  assign EN_BAR = en_bar_q;
  assign DOUT   = dout_q;
  assign DVALID = dvalid_q;
  assign SRC_ID = src_id_q;
  assign BUSY   = busy_q;

endmodule

// File: tb/tb_tinv_bus_rx_arb.sv
// Bench for tinv_bus_rx_arb: two configurations, each with a cycle-level reference
// model feeding a scoreboard queue and a monitor that checks the DUT against it.
module tb_tinv_bus_rx_arb;

  typedef struct {
    logic [7:0] d;
    int         s;
  } word_t;

  logic       clk;
  int         errors;
  int         checks;
  logic [1:0] done;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input int cfg, input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL cfg%0d %s: got %0h expected %0h", cfg, nm, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_cfg
    localparam int N  = (g == 0) ? 4 : 3;
    localparam int T  = (g == 0) ? 1 : 3;
    localparam int IW = $clog2(N);

    logic          rst;
    logic [N-1:0]  req, en, en_bar;
    logic [7:0]    bus, dout, junk;
    logic          dvalid, dready, busy;
    logic [IW-1:0] src_id;
    logic [7:0]    src_data [N];
    logic          blk_done;
    logic          probe_done, probe_hit;

    assign done[g] = blk_done;

    tinv_bus_rx_arb #(.NSRC(N), .W(8), .TURN(T)) u_dut (
      .CLK   (clk),
      .RST   (rst),
      .REQ   (req),
      .EN    (en),
      .EN_BAR(en_bar),
      .BUS   (bus),
      .DOUT  (dout),
      .DVALID(dvalid),
      .DREADY(dready),
      .SRC_ID(src_id),
      .BUSY  (busy)
    );

    // Inverting tristate drivers: the enabled source puts ~data on the bus, otherwise junk.
    always_comb begin
      bus = junk;
      for (int i = 0; i < N; i++)
        if (en[i]) bus = ~src_data[i];
    end

    // Reference model: grant source (-1 none), cooldown cycles left, output slot occupancy.
    int    m_grant = -1;
    int    m_cool  = 0;
    int    m_last  = N - 1;
    bit    m_full  = 1'b0;
    bit    m_zero  = 1'b1;
    word_t exp_q[$];

    always @(posedge clk) begin : model
      bit cap;
      int s;
      cap = 1'b0;
      if (rst) begin
        m_grant = -1;
        m_cool  = 0;
        m_last  = N - 1;
        m_full  = 1'b0;
        m_zero  = 1'b1;
        exp_q.delete();
      end else begin
        if (m_grant >= 0) begin
          exp_q.push_back('{d: src_data[m_grant], s: m_grant});
          m_grant = -1;
          m_cool  = T;
          m_zero  = 1'b0;
          cap     = 1'b1;
        end else if (m_cool > 0) begin
          m_cool--;
        end else if (req != '0 && (!m_full || dready)) begin
          for (int k = 1; k <= N; k++) begin
            s = (m_last + k) % N;
            if (req[s]) begin
              m_grant = s;
              m_last  = s;
              break;
            end
          end
        end
        m_full = cap || (m_full && !dready);
      end
    end

    always @(negedge clk) begin : monitor
      logic [N-1:0] exp_en;
      logic [N-1:0] inv_en;
      bit           probe_seen;
      #1;
      exp_en = '0;
      if (m_grant >= 0) exp_en[m_grant] = 1'b1;
      inv_en = ~en;
      chk(g, "en", 32'(en), 32'(exp_en));
      chk(g, "en_bar", 32'(en_bar), 32'(inv_en));
      chk(g, "busy", 32'(busy), 32'(m_grant >= 0 || m_cool > 0));
      chk(g, "dvalid", 32'(dvalid), 32'(m_full));
      if (dvalid) begin
        if (exp_q.size() == 0) begin
          chk(g, "dout_unexpected_word", 32'(dvalid), 32'(0));
        end else begin
          chk(g, "dout", 32'(dout), 32'(exp_q[0].d));
          chk(g, "src_id", 32'(src_id), 32'(exp_q[0].s));
          if (dready) void'(exp_q.pop_front());
        end
      end else if (m_zero) begin
        chk(g, "dout_reset", 32'(dout), 32'(0));
        chk(g, "src_id_reset", 32'(src_id), 32'(0));
      end
      if (probe_done && !probe_seen) begin
        chk(g, "grant1_seen", 32'(probe_hit), 32'(1));
        probe_seen = 1'b1;
      end
    end

    task automatic cyc(input logic [N-1:0] r, input logic rd, input logic rs);
      @(negedge clk);
      req    = r;
      dready = rd;
      rst    = rs;
      junk   = 8'($urandom);
    endtask

    initial begin : stim
      rst        = 1'b1;
      req        = '1;
      dready     = 1'b0;
      junk       = '0;
      blk_done   = 1'b0;
      probe_done = 1'b0;
      probe_hit  = 1'b0;
      for (int i = 0; i < N; i++) src_data[i] = 8'(8'h10 + i);

      repeat (3)  cyc('1, 1'b1, 1'b1);
      repeat (20) cyc('1, 1'b1, 1'b0);
      src_data[2] = 8'hA5;
      repeat (12) cyc(N'(4), 1'b1, 1'b0);
      repeat (14) cyc('1, 1'b0, 1'b0);
      repeat (10) cyc('1, 1'b1, 1'b0);
      repeat (16) cyc(N'(3), 1'b1, 1'b0);
      repeat (16) cyc(N'(5), 1'b1, 1'b0);

      // Hit reset while source 1 holds the bus, then release with sources 0 and 1 requesting.
      for (int i = 0; i < 60; i++) begin
        @(negedge clk);
        if (en[1]) begin
          probe_hit = 1'b1;
          break;
        end
        req    = N'(2);
        dready = 1'b1;
        rst    = 1'b0;
      end
      rst        = 1'b1;
      req        = N'(3);
      probe_done = 1'b1;
      repeat (12) cyc(N'(3), 1'b1, 1'b0);

      repeat (700) begin
        @(negedge clk);
        req    = N'($urandom);
        dready = ($urandom_range(0, 9) < 7);
        rst    = ($urandom_range(0, 149) == 0);
        junk   = 8'($urandom);
        src_data[$urandom_range(0, N - 1)] = 8'($urandom);
      end
      repeat (5) cyc('0, 1'b1, 1'b0);
      blk_done = 1'b1;
    end
  end

  initial begin
    errors = 0;
    checks = 0;
    wait (done == 2'b11);
    repeat (2) @(negedge clk);
    #3;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected done");
    $fatal(1);
  end

endmodule
